// File: rtl/hirose_present_scheduler_pkg.sv
// hirose_sched_pkg: shared state type and sizing helpers for the Hirose-PRESENT scheduler
package hirose_sched_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, RUN, RESP} sched_state_e;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_HASH_WIDTH = 128;
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction
endpackage

// File: rtl/hirose_present_scheduler_rr_arbiter.sv
// rr_arbiter: picks the first set request at or above the pointer, wrapping at N
module rr_arbiter
    import hirose_sched_pkg::*;
#(
    parameter int N = DEF_N_REQ,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_grant,
    output logic          o_found
);
    localparam logic [IW:0] N_W = (IW + 1)'(N);
    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_off;
    logic [IW:0]   w_sum;
    assign w_rot = N'({i_req, i_req} >> i_ptr);
    always_comb begin
        w_off = '0;
        for (int j = N - 1; j >= 0; j--)
            if (w_rot[j]) w_off = IW'(j);
    end
    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_grant = (w_sum >= N_W) ? IW'(w_sum - N_W) : w_sum[IW-1:0];
    assign o_found = |i_req;
endmodule

// File: rtl/hirose_present_scheduler.sv
// hirose_present_scheduler: shares one Hirose-PRESENT hash core among N_REQ requesters
module hirose_present_scheduler
    import hirose_sched_pkg::*;
#(
    parameter int N_REQ          = DEF_N_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int HASH_WIDTH     = DEF_HASH_WIDTH,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IW = idx_width(N_REQ),
    localparam int CW = cnt_width(SETUP_CYCLES, TIMEOUT_CYCLES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            resp_valid_o,
    input  logic [N_REQ-1:0]            resp_ready_i,
    output logic [HASH_WIDTH-1:0]       resp_hash_o,
    output logic                        resp_err_o,
    output logic                        core_rst_o,
    output logic [DATA_WIDTH-1:0]       core_plaintext_o,
    input  logic [HASH_WIDTH-1:0]       core_hash_i,
    input  logic                        core_end_i,
    output logic                        busy_o,
    output logic [IW-1:0]               grant_id_o
);
    localparam logic [N_REQ-1:0] ONE        = N_REQ'(1);
    localparam logic [IW-1:0]    LAST_IDX   = IW'(N_REQ - 1);
    localparam logic [CW-1:0]    SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0]    TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    sched_state_e          r_state, w_state;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic [IW-1:0]         r_gid, w_gid, r_ptr, w_ptr, w_grant;
    logic [DATA_WIDTH-1:0] r_pt, w_pt;
    logic [HASH_WIDTH-1:0] r_hash, w_hash;
    logic                  r_err, w_err, w_found;
    logic [DATA_WIDTH-1:0] w_data [N_REQ];
    for (genvar k = 0; k < N_REQ; k++) begin : g_data
        assign w_data[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_found (w_found)
    );
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_gid   = r_gid;
        w_ptr   = r_ptr;
        w_pt    = r_pt;
        w_hash  = r_hash;
        w_err   = r_err;
        case (r_state)
            IDLE: if (w_found) begin
                w_state = SETUP;
                w_cnt   = '0;
                w_gid   = w_grant;
                w_ptr   = (w_grant == LAST_IDX) ? '0 : w_grant + 1'b1;
                w_pt    = w_data[w_grant];
            end
            SETUP: begin
                w_state = (r_cnt == SETUP_LAST) ? RUN : SETUP;
                w_cnt   = (r_cnt == SETUP_LAST) ? '0 : r_cnt + 1'b1;
            end
            RUN: begin
                w_cnt = r_cnt + 1'b1;
                // an end flag left over from the previous hash is ignored on the first cycle
                if (core_end_i && r_cnt != '0) begin
                    w_state = RESP;
                    w_hash  = core_hash_i;
                    w_err   = 1'b0;
                end else if (r_cnt == TO_LAST) begin
                    w_state = RESP;
                    w_hash  = '0;
                    w_err   = 1'b1;
                end
            end
            RESP: w_state = resp_ready_i[r_gid] ? IDLE : RESP;
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gid   <= '0;
            r_ptr   <= '0;
            r_pt    <= '0;
            r_hash  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_gid   <= w_gid;
            r_ptr   <= w_ptr;
            r_pt    <= w_pt;
            r_hash  <= w_hash;
            r_err   <= w_err;
        end
    end
    assign req_ready_o      = (rst_n && r_state == IDLE && w_found) ? ONE << w_grant : '0;
    assign resp_valid_o     = (r_state == RESP) ? ONE << r_gid : '0;
    assign resp_hash_o      = r_hash;
    assign resp_err_o       = r_err;
    assign core_rst_o       = (r_state != RUN);
    assign core_plaintext_o = r_pt;
    assign busy_o           = (r_state != IDLE);
    assign grant_id_o       = r_gid;
endmodule

// File: tb/tb_hirose_present_scheduler.sv
// tb_hirose_present_scheduler: directed and randomized checks against a transaction-level model
module tb_hirose_present_scheduler;
    localparam int S  = 2;
    localparam int TO = 16;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic [3:0]   req_valid = '0, resp_ready = '0, req_ready, resp_valid;
    logic [63:0]  d [4];
    logic [255:0] req_data;
    logic [127:0] resp_hash, core_hash;
    logic [63:0]  core_pt;
    logic [1:0]   grant_id;
    logic         resp_err, core_rst, core_end, busy;
    int           total = 0, bad = 0, m_ptr = 0, stub_lat = 10, sc = 0;
    bit           stub_never = 0, stub_stale = 0;

    hirose_present_scheduler #(
        .N_REQ(4), .DATA_WIDTH(64), .HASH_WIDTH(128), .SETUP_CYCLES(S), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_hash_o(resp_hash), .resp_err_o(resp_err),
        .core_rst_o(core_rst), .core_plaintext_o(core_pt),
        .core_hash_i(core_hash), .core_end_i(core_end),
        .busy_o(busy), .grant_id_o(grant_id)
    );

    always #5 clk = ~clk;
    assign req_data  = {d[3], d[2], d[1], d[0]};
    // core stub: counts cycles out of reset, ends after stub_lat of them
    always @(posedge clk) sc <= core_rst ? 0 : sc + 1;
    assign core_end  = !core_rst && !stub_never && (sc == stub_lat - 1 || (stub_stale && sc == 0));
    assign core_hash = {core_pt, ~core_pt};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [3:0] v);
        for (int i = 0; i < 4; i++)
            if (v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        return 0;
    endfunction

    // one request-to-response transaction, entered and left in an idle window
    task automatic txn(input logic [3:0] v, input int hold, input string tag);
        int g, n, low, run_len;
        bit leak;
        logic [63:0]  pt;
        logic [127:0] eh;
        logic [3:0]   oh;
        g = model_grant(v);
        oh = 4'b1 << g;
        pt = d[g];
        eh = stub_never ? 128'h0 : {pt, ~pt};
        run_len = stub_never ? TO : stub_lat;
        req_valid = v;
        #1;
        chk({tag, ":req_ready"}, req_ready, oh);
        m_ptr = (g + 1) % 4;
        tick;
        chk({tag, ":grant_id"}, grant_id, g);
        chk({tag, ":plaintext"}, core_pt, pt);
        chk({tag, ":busy"}, busy, 1);
        n = 1; low = 0; leak = 0;
        while (resp_valid == 4'b0 && n < 60) begin
            low += int'(!core_rst);
            leak |= (req_ready != 4'b0);
            tick;
            n++;
        end
        chk({tag, ":latency"}, n, 1 + S + run_len);
        chk({tag, ":run_cycles"}, low, run_len);
        chk({tag, ":no_grant_busy"}, leak, 0);
        chk({tag, ":resp_valid"}, resp_valid, oh);
        chk({tag, ":hash"}, resp_hash, eh);
        chk({tag, ":err"}, resp_err, stub_never);
        chk({tag, ":core_rst"}, core_rst, 1);
        resp_ready = ~oh;
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({tag, ":hold_valid"}, resp_valid, oh);
            chk({tag, ":hold_hash"}, resp_hash, eh);
            chk({tag, ":hold_ready"}, req_ready, 0);
        end
        resp_ready = oh;
        tick;
        resp_ready = '0;
        chk({tag, ":idle_busy"}, busy, 0);
        chk({tag, ":idle_valid"}, resp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] v;
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        tick;
        chk("rst:core_rst", core_rst, 1);
        chk("rst:plaintext", core_pt, 0);
        chk("rst:req_ready", req_ready, 0);
        chk("rst:resp_valid", resp_valid, 0);
        chk("rst:hash", resp_hash, 0);
        chk("rst:err", resp_err, 0);
        chk("rst:busy", busy, 0);
        chk("rst:grant_id", grant_id, 0);
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < 5; i++) begin
            txn(4'b1111, 0, "rr");
            chk("rr:order", grant_id, exp_order[i]);
        end
        d[1] = 64'h0123456789ABCDEF;
        txn(4'b0010, 0, "single");
        chk("single:hash_const", resp_hash, 128'h0123456789ABCDEF_FEDCBA9876543210);
        txn(4'b0011, 5, "bp");
        txn(4'b0011, 0, "bp_next");
        stub_never = 1;
        txn(4'b0100, 0, "timeout");
        stub_never = 0;
        stub_stale = 1;
        txn(4'b1000, 0, "stale");
        stub_stale = 0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
            stub_lat = $urandom_range(2, 12);
            v = 4'($urandom_range(1, 15));
            txn(v, $urandom_range(0, 3), "rand");
        end
        stub_lat = 10;
        d[2] = {$urandom, $urandom};
        req_valid = 4'b0100;
        tick;
        k = 0;
        while (core_rst && k < 10) begin
            tick;
            k++;
        end
        repeat (3) tick;
        chk("midrst:in_run", core_rst, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst:core_rst", core_rst, 1);
        chk("midrst:plaintext", core_pt, 0);
        chk("midrst:req_ready", req_ready, 0);
        chk("midrst:resp_valid", resp_valid, 0);
        chk("midrst:hash", resp_hash, 0);
        chk("midrst:err", resp_err, 0);
        chk("midrst:busy", busy, 0);
        chk("midrst:grant_id", grant_id, 0);
        req_valid = '0;
        tick;
        rst_n = 1'b1;
        m_ptr = 0;
        tick;
        chk("midrst:no_resp", resp_valid, 0);
        txn(4'b1111, 0, "post_rst");
        txn(4'b0001, 0, "post_rst_req0");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
